// File: rtl/irq_pkg.sv
// Shared types, cause codes and the source-to-cause mapping for the interrupt controller.
package irq_pkg;

  localparam int unsigned CODE_W = 6;
  localparam logic [CODE_W-1:0] NONE_CODE = 6'h1F;

  localparam logic [CODE_W-1:0] CODE_SSI = 6'h01;
  localparam logic [CODE_W-1:0] CODE_MSI = 6'h03;
  localparam logic [CODE_W-1:0] CODE_STI = 6'h05;
  localparam logic [CODE_W-1:0] CODE_MTI = 6'h07;
  localparam logic [CODE_W-1:0] CODE_SEI = 6'h09;
  localparam logic [CODE_W-1:0] CODE_MEI = 6'h0B;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } irq_state_t;

  // Sources 0..5 are the architectural S/M interrupts; the rest pack above custom_base.
  function automatic logic [CODE_W-1:0] src_to_code(input int unsigned idx,
                                                    input logic [CODE_W-1:0] custom_base);
    logic [CODE_W-1:0] code;
    case (idx)
      0:       code = CODE_SSI;
      1:       code = CODE_MSI;
      2:       code = CODE_STI;
      3:       code = CODE_MTI;
      4:       code = CODE_SEI;
      5:       code = CODE_MEI;
      default: code = custom_base + CODE_W'(idx - 32'd6);
    endcase
    return code;
  endfunction

endpackage

// File: rtl/irq_if.sv
// Core-facing interrupt interface: raw lines and masks in, request/cause/status out.
interface irq_if #(
  parameter int unsigned NUM_SRC = 16,
  parameter int unsigned CODE_W  = irq_pkg::CODE_W
);
  logic [NUM_SRC-1:0] irq_i;
  logic [NUM_SRC-1:0] enable_i;
  logic               global_en_i;
  logic               claim_i;
  logic               complete_i;
  logic               irq_req_o;
  logic [CODE_W-1:0]  code_o;
  logic               busy_o;
  logic [NUM_SRC-1:0] pending_o;

  modport master (
    output irq_i, enable_i, global_en_i, claim_i, complete_i,
    input  irq_req_o, code_o, busy_o, pending_o
  );

  modport slave (
    input  irq_i, enable_i, global_en_i, claim_i, complete_i,
    output irq_req_o, code_o, busy_o, pending_o
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins.
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 16,
  parameter int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (!valid && req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge/level capture, enable masking, fixed-priority arbitration
// and a claim/complete handshake so only one interrupt is in service at a time.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned          NUM_SRC     = 16,
  parameter int unsigned          CODE_W      = irq_pkg::CODE_W,
  parameter logic [CODE_W-1:0]    NONE_CODE   = irq_pkg::NONE_CODE,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK   = '0,
  parameter logic [CODE_W-1:0]    CUSTOM_BASE = 6'h10
) (
  input logic  clk,
  input logic  rst_n,
  irq_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned PKG_W = irq_pkg::CODE_W;

  if (NUM_SRC < 1 || NUM_SRC > 32) begin : g_bad_num_src
    $error("irq_controller: NUM_SRC must be in 1..32");
  end
  if (NUM_SRC > 6 &&
      (int'(CUSTOM_BASE) + int'(NUM_SRC) - 7 >= int'(NONE_CODE))) begin : g_bad_code_map
    $error("irq_controller: custom cause codes collide with NONE_CODE or overflow CODE_W");
  end

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx, win_idx_q;
  logic               irq_req_q;
  logic [CODE_W-1:0]  code_q;
  logic               claim_take;
  irq_state_t         state_q, state_d;

  assign eligible   = pending_q & bus.enable_i;
  assign rise       = bus.irq_i & ~irq_q;
  assign claim_take = bus.claim_i && irq_req_q && (state_q == IDLE);

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // The claim consumes the registered winner the core saw; a fresh edge in the same cycle re-arms it.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = rise[i] |
                       (pending_q[i] & ~(claim_take && (win_idx_q == IDX_W'(i))));
      end else begin
        pending_d[i] = bus.irq_i[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (claim_take)     state_d = BUSY;
      BUSY:    if (bus.complete_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is built from the pre-edge state, giving a one-cycle gap after complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      irq_req_q <= 1'b0;
      code_q    <= NONE_CODE;
      win_idx_q <= '0;
    end else begin
      irq_q     <= bus.irq_i;
      pending_q <= pending_d;
      state_q   <= state_d;
      irq_req_q <= (state_q == IDLE) && !claim_take && bus.global_en_i && win_valid;
      code_q    <= win_valid ? CODE_W'(src_to_code(32'(win_idx), PKG_W'(CUSTOM_BASE)))
                             : NONE_CODE;
      win_idx_q <= win_idx;
    end
  end

  assign bus.irq_req_o = irq_req_q;
  assign bus.code_o    = code_q;
  assign bus.busy_o    = (state_q == BUSY);
  assign bus.pending_o = pending_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt controller between raw interrupt lines (software/timer/external, S/M mode, plus custom sources) and the core's trap logic.
- Adds per-source enable masking, per-source edge/level capture and a pending register.
- Arbitrates by fixed priority (lowest index wins) and drives a registered cause code.
- Claim/complete handshake with the core, so one interrupt is in service at a time and edge events are never lost.

Parameters:
- NUM_SRC, 16, number of interrupt sources (1..32).
- CODE_W, 6, width of cause code output.
- NONE_CODE, 6'h1F, code driven when nothing is eligible.
- EDGE_MASK, 16'h0000, bit i = 1: source i is rising-edge captured; 0: level.
- CUSTOM_BASE, 6'h10, code of source 6; source i >= 6 maps to CUSTOM_BASE + (i-6).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_i  in  NUM_SRC  raw interrupt lines, synchronous to clk
- enable_i  in  NUM_SRC  per-source enable mask (mie-style)
- global_en_i  in  1  global interrupt enable (mstatus.MIE-style)
- irq_req_o  out  1  eligible interrupt present, core may trap
- code_o  out  CODE_W  cause code of highest-priority eligible source, else NONE_CODE
- claim_i  in  1  core takes the trap this cycle; valid only when irq_req_o = 1
- complete_i  in  1  core finished the handler (mret)
- busy_o  out  1  an interrupt is in service
- pending_o  out  NUM_SRC  pending register, for CSR mip read-back

Behaviour:
- Reset (async, rst_n = 0): pending = 0, in-service id cleared, FSM IDLE, irq_q = 0, irq_req_o = 0, code_o = NONE_CODE, busy_o = 0.
- Capture, every cycle:
  - Level source: pending[i] = irq_i[i].
  - Edge source: pending[i] is set on irq_i[i] & ~irq_q[i] and held until claimed.
  - irq_q is the registered copy of irq_i.
- Eligible = pending & enable_i.
- Priority: lowest index wins.
- Code map: 0→1, 1→3, 2→5, 3→7, 4→9, 5→B, i >= 6 → CUSTOM_BASE + (i-6).
- Output timing: code_o and irq_req_o are registered, one cycle after pending changes.
  - irq_req_o = 1 iff state == IDLE, global_en_i = 1 and eligible != 0.
  - code_o shows the winner even when masked by global_en_i or BUSY (for CSR read); NONE_CODE when eligible == 0.
- FSM:
  - IDLE → BUSY on claim_i & irq_req_o. Latches winner index into svc_id and clears pending[svc_id] if edge. Level pending is not cleared; the handler must clear the source.
  - BUSY → IDLE on complete_i. busy_o = 1 in BUSY.
  - claim_i in BUSY or with irq_req_o = 0: ignored.
  - complete_i in IDLE: ignored.
- Simultaneous events:
  - Edge arriving on svc_id in the same cycle as its claim: the new edge wins, pending stays 1 (no lost event).
  - claim_i and complete_i together in IDLE: claim taken, complete ignored.
- Disabled sources still capture into pending (visible on pending_o) but never win.
- The claimed winner is the registered code_o/index, not the combinational one, so the core sees a consistent code.
- No interrupt after complete until the next registered update (one-cycle gap).
- Width rules:
  - NUM_SRC <= 32.
  - Elaboration check: CUSTOM_BASE + NUM_SRC - 7 must fit CODE_W and stay below NONE_CODE.

Decomposition:
- Shared package irq_pkg holds:
  - CODE_W.
  - NONE_CODE.
  - Named codes CODE_SSI = 1, CODE_MSI = 3, CODE_STI = 5, CODE_MTI = 7, CODE_SEI = 9, CODE_MEI = B.
  - FSM enum irq_state_t {IDLE, BUSY}.
  - Function src_to_code(index).
- One sub-module: irq_prio_enc, parametrised combinational priority encoder (NUM_SRC → valid + index).

Test Plan:
- Reset mid-service: claim source 3 then pull rst_n low → pending = 0, busy_o = 0, code_o = 6'h1F immediately, without waiting for a clock edge.
- Priority: level irq_i = 16'h0030, enable all, global_en_i = 1 → next cycle irq_req_o = 1, code_o = 6'h09. Then irq_i = 16'h0020 → code_o = 6'h0B.
- Mask: irq_i[1] = 1, enable_i[1] = 0, enable_i[2] = 1, irq_i[2] = 1 → code_o = 6'h05, pending_o = 16'h0006. With global_en_i = 0 → irq_req_o = 0, code_o unchanged.
- Edge capture and claim (EDGE_MASK = 16'h0040):
  - 1-cycle pulse on irq_i[6] → pending_o[6] stays 1, code_o = 6'h10.
  - claim_i → busy_o = 1, pending_o[6] = 0, irq_req_o = 0.
  - complete_i → IDLE.
- Lost-edge corner: second irq_i[6] rising edge in the same cycle as claim → after claim, pending_o[6] = 1. After complete, irq_req_o = 1 again with code 6'h10.
- Nesting block: in BUSY assert irq_i[0] → irq_req_o = 0, claim_i ignored. complete_i → one cycle later irq_req_o = 1, code_o = 6'h01.
